// File: rtl/sign_mag_pkg.sv
// Shared width constants for the sign-magnitude adder.
// The result is one bit wider than the operands so that the magnitude carry is absorbed.
package sign_mag_pkg;

  localparam int W_DEFAULT = 8;

  function automatic int res_width(input int w);
    return w + 1;
  endfunction

endpackage

// File: rtl/sign_mag_core.sv
// Combinational sign-magnitude add/subtract.
// A zero-magnitude result is always emitted as +0.
module sign_mag_core
  import sign_mag_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic [W-1:0]              a,
  input  logic [W-1:0]              b,
  output logic [res_width(W)-1:0]   sum
);

  logic         a_sign;
  logic         b_sign;
  logic [W-1:0] a_ext;
  logic [W-1:0] b_ext;
  logic [W-1:0] mag;
  logic         raw_sign;

  assign a_sign = a[W-1];
  assign b_sign = b[W-1];
  assign a_ext  = {1'b0, a[W-2:0]};
  assign b_ext  = {1'b0, b[W-2:0]};

  always_comb begin
    mag      = '0;
    raw_sign = 1'b0;
    if (a_sign == b_sign) begin
      mag      = a_ext + b_ext;
      raw_sign = a_sign;
    end else if (a_ext > b_ext) begin
      mag      = a_ext - b_ext;
      raw_sign = a_sign;
    end else begin
      mag      = b_ext - a_ext;
      raw_sign = b_sign;
    end
  end

  // Masking the sign with a nonzero magnitude covers both -0 inputs and equal-magnitude cancellation.
  assign sum = {raw_sign & (|mag), mag};

endmodule

// File: rtl/sign_mag_adder.sv
// Registered sign-magnitude adder with one-cycle latency and no backpressure.
// Reset is synchronous and active-low.
module sign_mag_adder
  import sign_mag_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [W-1:0]              a,
  input  logic [W-1:0]              b,
  output logic                      out_valid,
  output logic [res_width(W)-1:0]   sum
);

  logic [res_width(W)-1:0] core_sum;

  sign_mag_core #(.W(W)) u_core (
    .a   (a),
    .b   (b),
    .sum (core_sum)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum       <= '0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      sum       <= core_sum;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sign_mag_adder.sv
// Directed-vector bench for sign_mag_adder at the default width of 8.
module tb_sign_mag_adder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic [8:0] sum;

  int total;
  int bad;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] exp_sum;
  } vec_t;

  vec_t vecs [15];

  sign_mag_adder #(.W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .sum       (sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;

    vecs[0]  = '{8'h86, 8'h83, 9'h109};
    vecs[1]  = '{8'h96, 8'h87, 9'h11D};
    vecs[2]  = '{8'h7F, 8'h7F, 9'h0FE};
    vecs[3]  = '{8'hFF, 8'hFF, 9'h1FE};
    vecs[4]  = '{8'h05, 8'h85, 9'h000};
    vecs[5]  = '{8'h80, 8'h80, 9'h000};
    vecs[6]  = '{8'h03, 8'h8A, 9'h107};
    vecs[7]  = '{8'h80, 8'h05, 9'h005};
    vecs[8]  = '{8'h00, 8'h80, 9'h000};
    vecs[9]  = '{8'h8A, 8'h03, 9'h107};
    vecs[10] = '{8'h0A, 8'h83, 9'h007};
    vecs[11] = '{8'h00, 8'h00, 9'h000};
    vecs[12] = '{8'h14, 8'h0C, 9'h020};
    vecs[13] = '{8'h85, 8'h00, 9'h105};
    vecs[14] = '{8'hFF, 8'h7F, 9'h000};

    rst_n    = 1'b0;
    in_valid = 1'b1;
    a        = 8'h7F;
    b        = 8'h7F;
    repeat (2) @(posedge clk);
    #1;
    check("reset_sum", sum, 9'h000);
    check("reset_valid", {8'h00, out_valid}, 9'h000);

    @(negedge clk);
    rst_n = 1'b1;
    // in_valid stays high across iterations, so this is a back-to-back stream
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a        = vecs[i].a;
      b        = vecs[i].b;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_sum", i), sum, vecs[i].exp_sum);
      check($sformatf("vec%0d_valid", i), {8'h00, out_valid}, 9'h001);
    end

    // idle cycles: out_valid drops, sum holds the last result
    @(negedge clk);
    in_valid = 1'b0;
    a        = 8'h01;
    b        = 8'h01;
    @(posedge clk);
    #1;
    check("idle_valid", {8'h00, out_valid}, 9'h000);
    check("idle_hold", sum, 9'h000);

    @(negedge clk);
    in_valid = 1'b1;
    a        = 8'h96;
    b        = 8'h87;
    @(posedge clk);
    #1;
    check("pre_idle_sum", sum, 9'h11D);
    @(negedge clk);
    in_valid = 1'b0;
    a        = 8'h01;
    b        = 8'h02;
    repeat (2) @(posedge clk);
    #1;
    check("idle2_valid", {8'h00, out_valid}, 9'h000);
    check("idle2_hold", sum, 9'h11D);

    // reset in the middle of a stream discards the in-flight sample
    @(negedge clk);
    in_valid = 1'b1;
    a        = 8'h7F;
    b        = 8'h7F;
    rst_n    = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_sum", sum, 9'h000);
    check("midrst_valid", {8'h00, out_valid}, 9'h000);

    @(negedge clk);
    rst_n = 1'b1;
    a     = 8'h86;
    b     = 8'h83;
    @(posedge clk);
    #1;
    check("postrst_sum", sum, 9'h109);
    check("postrst_valid", {8'h00, out_valid}, 9'h001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
